operand_fetch: RTL

- Issue stage that sits directly upstream of the 32x32 register file.
- Accepts decoded instructions (rs, rt, rd) over a valid/ready handshake and drives ReadRegister1/ReadRegister2 into the regfile.
- Captures ReadData1/ReadData2, or bypassed writeback data, into a pipeline register for the execute stage.
- Tracks in-flight destination registers in a scoreboard and stalls on RAW and WAW hazards.

---
 rtl/opfetch_pkg.sv | 13 +
 rtl/opfetch_scoreboard.sv | 54 +++++
 rtl/operand_fetch.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/opfetch_pkg.sv
// Shared defaults for the operand-fetch issue stage.
// Holds the default widths and the hardwired-zero register index.
// Imported by operand_fetch and opfetch_scoreboard.
package opfetch_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_NREGS  = 32;

  // Register 0 reads as zero and is never tracked as pending.
  localparam logic [4:0] ZERO_REG = 5'd0;

endpackage

// File: rtl/opfetch_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register with an in-flight write.
// Latency: set/clear take effect at the next edge; lookups are combinational on the current mask.
// Backpressure: none internally; the caller only sets a bit on an accepted instruction.
module opfetch_scoreboard
  import opfetch_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NREGS  = DEF_NREGS
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              set_vld_i,
  input  logic [ADDR_W-1:0] set_reg_i,
  input  logic              clr_vld_i,
  input  logic [ADDR_W-1:0] clr_reg_i,
  input  logic [ADDR_W-1:0] rs_i,
  input  logic [ADDR_W-1:0] rt_i,
  input  logic [ADDR_W-1:0] rd_i,
  output logic [NREGS-1:0]  pending_o,
  output logic              rs_pend_o,
  output logic              rt_pend_o,
  output logic              rd_pend_o
);

  logic [NREGS-1:0] pend_q;
  logic [NREGS-1:0] pend_d;

  // Next mask: clear on writeback first so a same-cycle set on that register wins; r0 never pending.
  always_comb begin
    pend_d = pend_q;
    if (clr_vld_i) begin
      pend_d[clr_reg_i] = 1'b0;
    end
    if (set_vld_i) begin
      pend_d[set_reg_i] = 1'b1;
    end
    pend_d[ZERO_REG] = 1'b0;
  end

  // Mask register; reset drops every in-flight write.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  assign pending_o = pend_q;
  assign rs_pend_o = pend_q[rs_i];
  assign rt_pend_o = pend_q[rt_i];
  assign rd_pend_o = pend_q[rd_i];

endmodule

// File: rtl/operand_fetch.sv
// Issue stage: reads two regfile operands (or a same-cycle writeback) into an output register, stalling on RAW/WAW.
// Latency: 1 cycle from accept to OutValid. Optional macro OPFETCH_BYPASS_EN lets a same-cycle writeback resolve RAW.
// Backpressure: InReady drops while the output register is held (OutValid & !OutReady) or a hazard exists.
module operand_fetch
  import opfetch_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NREGS  = DEF_NREGS
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              InValid,
  output logic              InReady,
  input  logic [ADDR_W-1:0] InRs,
  input  logic [ADDR_W-1:0] InRt,
  input  logic [ADDR_W-1:0] InRd,
  input  logic              InWritesRd,
  output logic [ADDR_W-1:0] ReadRegister1,
  output logic [ADDR_W-1:0] ReadRegister2,
  input  logic [DATA_W-1:0] ReadData1,
  input  logic [DATA_W-1:0] ReadData2,
  input  logic              WbValid,
  input  logic [ADDR_W-1:0] WbReg,
  input  logic [DATA_W-1:0] WbData,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [DATA_W-1:0] OutA,
  output logic [DATA_W-1:0] OutB,
  output logic [ADDR_W-1:0] OutRd,
  output logic              OutWritesRd,
  output logic [NREGS-1:0]  PendingMask
);

  localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(ZERO_REG);

  logic              out_vld_q, out_vld_d;
  logic [DATA_W-1:0] out_a_q, out_a_d;
  logic [DATA_W-1:0] out_b_q, out_b_d;
  logic [ADDR_W-1:0] out_rd_q, out_rd_d;
  logic              out_wr_q, out_wr_d;

  logic rs_pend, rt_pend, rd_pend;
  logic rs_nz, rt_nz, rd_nz;
  logic byp_rs, byp_rt;
  logic wb_hits_rd;
  logic hazard, free, accept;
  logic [DATA_W-1:0] op_a, op_b;

  // The regfile is read combinationally with the incoming source addresses.
  assign ReadRegister1 = InRs;
  assign ReadRegister2 = InRt;

  assign rs_nz = (InRs != ZERO);
  assign rt_nz = (InRt != ZERO);
  assign rd_nz = (InRd != ZERO);

`ifdef OPFETCH_BYPASS_EN
  // A writeback landing this cycle supplies the operand directly, so it resolves RAW.
  assign byp_rs = WbValid && (WbReg == InRs) && (WbReg != ZERO);
  assign byp_rt = WbValid && (WbReg == InRt) && (WbReg != ZERO);
`else
  // Without bypass the operand waits one cycle and is then read from the regfile.
  logic unused_wb_data;
  assign unused_wb_data = ^WbData;
  assign byp_rs = 1'b0;
  assign byp_rt = 1'b0;
`endif

  // The old write retiring this cycle frees the register for a new writer (WAW).
  assign wb_hits_rd = WbValid && (WbReg == InRd);

  assign hazard = (rs_nz && rs_pend && !byp_rs) ||
                  (rt_nz && rt_pend && !byp_rt) ||
                  (InWritesRd && rd_nz && rd_pend && !wb_hits_rd);

  assign free    = !out_vld_q || OutReady;
  assign InReady = free && !hazard;
  assign accept  = InValid && InReady;

  // Operand select: zero register, then bypassed writeback, then regfile data.
  always_comb begin
    op_a = '0;
    op_b = '0;
    if (rs_nz) begin
      op_a = byp_rs ? WbData : ReadData1;
    end
    if (rt_nz) begin
      op_b = byp_rt ? WbData : ReadData2;
    end
  end

  opfetch_scoreboard #(
    .ADDR_W (ADDR_W),
    .NREGS  (NREGS)
  ) u_scoreboard (
    .clk_i     (Clk),
    .rst_ni    (Reset_n),
    .set_vld_i (accept && InWritesRd && rd_nz),
    .set_reg_i (InRd),
    .clr_vld_i (WbValid),
    .clr_reg_i (WbReg),
    .rs_i      (InRs),
    .rt_i      (InRt),
    .rd_i      (InRd),
    .pending_o (PendingMask),
    .rs_pend_o (rs_pend),
    .rt_pend_o (rt_pend),
    .rd_pend_o (rd_pend)
  );

  // Output register next state: load on accept, drop valid when consumed, otherwise hold.
  always_comb begin
    out_vld_d = out_vld_q;
    out_a_d   = out_a_q;
    out_b_d   = out_b_q;
    out_rd_d  = out_rd_q;
    out_wr_d  = out_wr_q;
    if (accept) begin
      out_vld_d = 1'b1;
      out_a_d   = op_a;
      out_b_d   = op_b;
      out_rd_d  = InRd;
      out_wr_d  = InWritesRd;
    end else if (OutReady) begin
      out_vld_d = 1'b0;
    end
  end

  // Output register; reset discards any held instruction.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      out_vld_q <= 1'b0;
      out_a_q   <= '0;
      out_b_q   <= '0;
      out_rd_q  <= '0;
      out_wr_q  <= 1'b0;
    end else begin
      out_vld_q <= out_vld_d;
      out_a_q   <= out_a_d;
      out_b_q   <= out_b_d;
      out_rd_q  <= out_rd_d;
      out_wr_q  <= out_wr_d;
    end
  end

  assign OutValid    = out_vld_q;
  assign OutA        = out_a_q;
  assign OutB        = out_b_q;
  assign OutRd       = out_rd_q;
  assign OutWritesRd = out_wr_q;

endmodule
